// File: rtl/ifmap_pack_pkg.sv
// Shared widths and helpers for the ifmap packer and its PE-array consumers.
// Optional early-close feature is enabled by defining IFMAP_PACK_FLUSH_EN.
package ifmap_pack_pkg;

   localparam int IFMAP_IN_W  = 8;
   localparam int IFMAP_LANES = 4;
   localparam int IFMAP_OUT_W = IFMAP_IN_W * IFMAP_LANES;

   // Fill counter has to reach LANES-1 and still represent a full word's beat count.
   function automatic int ifmap_cnt_w(input int lanes);
      return $clog2(lanes) + 1;
   endfunction

   typedef struct packed {
      logic [IFMAP_LANES-1:0] keep;
      logic [IFMAP_OUT_W-1:0] data;
   } ifmap_word_t;

endpackage

// File: rtl/ifmap_pack_oreg.sv
// Output register of the ifmap packer: loads a finished word, holds it until the consumer takes it.
// Data payload width is generic so the keep bundle (IFMAP_PACK_FLUSH_EN builds) rides along.
module ifmap_pack_oreg
   import ifmap_pack_pkg::*;
#(
   parameter int DW = IFMAP_OUT_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   // A load may coincide with the consumer taking the old word; the new word wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ifmap_packer.sv
// Serial-to-parallel ifmap packer: LANES beats of IN_W bits form one word, first beat in the LSB lane.
// Define IFMAP_PACK_FLUSH_EN to add in_last (early word close) and out_keep (valid-lane mask).
module ifmap_packer
   import ifmap_pack_pkg::*;
#(
   parameter int IN_W  = IFMAP_IN_W,
   parameter int LANES = IFMAP_LANES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_data,
`ifdef IFMAP_PACK_FLUSH_EN
   input  logic                  in_last,
   output logic [LANES-1:0]      out_keep,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [IN_W*LANES-1:0] out_data,
   output logic                  busy
);

   localparam int OUT_W = IN_W * LANES;
   localparam int CNT_W = ifmap_cnt_w(LANES);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
`ifdef IFMAP_PACK_FLUSH_EN
   localparam int DW = OUT_W + LANES;
`else
   localparam int DW = OUT_W;
`endif

   logic [CNT_W-1:0] cnt;
   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] word_next;
   logic             completing;
   logic             beat_acc;
   logic             word_load;
   logic [DW-1:0]    load_data;
   logic [DW-1:0]    oreg_q;

   // Accumulator with the incoming beat dropped into lane cnt; unfilled lanes are already zero.
   always_comb begin
      word_next = acc;
      for (int k = 0; k < LANES; k++) begin
         if (CNT_W'(k) == cnt) word_next[k*IN_W +: IN_W] = in_data;
      end
   end

`ifdef IFMAP_PACK_FLUSH_EN
   logic [LANES-1:0] keep_next;

   always_comb begin
      keep_next = '0;
      for (int k = 0; k < LANES; k++) begin
         if (CNT_W'(k) <= cnt) keep_next[k] = 1'b1;
      end
   end

   assign completing = (cnt == LAST_LANE) || in_last;
   assign load_data  = {keep_next, word_next};
   assign out_keep   = oreg_q[OUT_W +: LANES];
   assign out_data   = oreg_q[OUT_W-1:0];
`else
   assign completing = (cnt == LAST_LANE);
   assign load_data  = word_next;
   assign out_data   = oreg_q;
`endif

   // Only a completing beat needs room in the output register.
   assign in_ready  = !completing || !out_valid || out_ready;
   assign beat_acc  = in_valid && in_ready;
   assign word_load = beat_acc && completing;
   assign busy      = (cnt != '0) || out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (beat_acc) begin
         if (completing) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            acc <= word_next;
         end
      end
   end

   ifmap_pack_oreg #(
      .DW (DW)
   ) u_oreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (word_load),
      .load_data (load_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (oreg_q)
   );

endmodule
